pixel_readout: RTL and testbench

Captures pixel samples for the two-row sensor during the readout phase driven by the exposure controller's `NRE_1`, `NRE_2` and `ADC` strobes. Each valid conversion window yields two column samples, which are pushed into a small output FIFO. The FIFO presents them one pixel at a time to the downstream image store over a valid/ready handshake. The block sits directly downstream of the exposure control FSM and upstream of frame storage/display.

---
 rtl/pixel_readout_pkg.sv | 33 +++
 rtl/pixel_readout_if.sv | 43 ++++
 rtl/pixel_readout_fifo.sv | 82 ++++++++
 rtl/pixel_readout.sv | 216 +++++++++++++++++++++
 tb/tb_pixel_readout.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_readout_pkg
// Purpose  : Shared types and defaults for the two-row pixel readout block.
//            Holds the capture FSM state enum, the FIFO entry layout and the
//            default sample width.
// Contents : c_DATA_W     - default bits per pixel sample
//            ro_state_t   - readout FSM states
//            pix_entry_t  - one FIFO entry {data, row, col} at default width
// Revision : 1.0 - initial release
// ============================================================================
package pixel_readout_pkg;

    localparam int c_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PUSH0   = 3'd3,
        ST_PUSH1   = 3'd4
    } ro_state_t;

    // Field order matches the packed FIFO word used by the top level:
    // data in the upper bits, then row, then column in bit 0.
    typedef struct packed {
        logic [c_DATA_W-1:0] data;
        logic                row;
        logic                col;
    } pix_entry_t;

endpackage : pixel_readout_pkg
`default_nettype wire

// File: rtl/pixel_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_readout_if
// Purpose  : Pixel stream from the readout FIFO to the image store, using a
//            valid/ready handshake. A pixel transfers on a cycle where both
//            pix_valid and pix_ready are high.
// Signals  : pix_data  - head-of-FIFO pixel sample
//            pix_row   - 0 = row 1, 1 = row 2
//            pix_col   - column index
//            pix_valid - head entry present
//            pix_ready - sink accepts the head entry
// Modports : master (pixel source), slave (pixel sink)
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_readout_if
    import pixel_readout_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_row;
    logic              pix_col;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output pix_data,
        output pix_row,
        output pix_col,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_row,
        input  pix_col,
        input  pix_valid,
        output pix_ready
    );

endinterface : pixel_readout_if
`default_nettype wire

// File: rtl/pixel_readout_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pix_fifo
// Purpose  : First-word-fall-through FIFO for readout pixels. The head entry
//            is visible on rd_data_o whenever empty_o is low. A write into a
//            full FIFO is accepted only if a read happens in the same cycle.
//            A read on an empty FIFO is ignored. flush_i empties the FIFO
//            synchronously and overrides reads and writes.
// Ports    : clk, reset   - clock, asynchronous active-high reset
//            flush_i      - synchronous empty
//            wr_en_i      - write request, wr_data_i - write word
//            rd_en_i      - read request (pop head)
//            rd_data_o    - head word (zero while empty)
//            empty_o      - no entries, full_o - DEPTH entries
// Revision : 1.0 - initial release
// ============================================================================
module pix_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int c_AW = $clog2(DEPTH);

    // One extra pointer bit separates the full and empty cases when the
    // address bits are equal.
    logic [c_AW:0]      wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               w_do_wr;
    logic               w_do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);

    assign w_do_rd = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot the write needs.
    assign w_do_wr = wr_en_i && (!full_o || w_do_rd);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[c_AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the read port masks it while empty.
    always_ff @(posedge clk) begin
        if (w_do_wr && !flush_i) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= wr_data_i;
        end
    end

endmodule : pix_fifo
`default_nettype wire

// File: rtl/pixel_readout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_readout
// Purpose  : Captures two column samples per ADC conversion window of the
//            two-row sensor and streams them one pixel at a time through a
//            small FWFT FIFO to the image store.
//            Build option: define DARK_SUB_EN to subtract DARK_LEVEL from
//            each sample (saturating at zero) during capture.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            NRE_1, NRE_2        - row read enables, active-low
//            ADC                 - conversion window, active-high
//            erase               - synchronous flush of the whole block
//            adc_data            - {column 1, column 0} samples
//            pix                 - pixel stream (pixel_readout_if.master)
//            frame_done          - pulse after row 2 column 1 is written
//            overflow            - sticky, a sample was dropped on full FIFO
//            seq_err             - sticky, bad strobe combo or aborted window
// Revision : 1.0 - initial release
// ============================================================================
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int SETTLE     = 3,
    parameter int DEPTH      = 4,
    parameter int DARK_LEVEL = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                NRE_1,
    input  logic                NRE_2,
    input  logic                ADC,
    input  logic                erase,
    input  logic [2*DATA_W-1:0] adc_data,
    pixel_readout_if.master     pix,
    output logic                frame_done,
    output logic                overflow,
    output logic                seq_err
);

    localparam int c_FW = DATA_W + 2;

    // Elaboration-time sanity check of the configuration.
    generate
        if (SETTLE < 1 || SETTLE > 15 || DEPTH < 2 ||
            (DEPTH & (DEPTH - 1)) != 0 ||
            DARK_LEVEL < 0 || DARK_LEVEL >= (1 << DATA_W)) begin : g_bad_cfg
            $error("pixel_readout: illegal parameter combination");
        end
    endgenerate

    ro_state_t           state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                row_q, row_d;
    logic [2*DATA_W-1:0] cap_q, cap_d;
    logic                adc_q;
    logic                seq_err_q, seq_err_d;
    logic                overflow_q, overflow_d;
    logic                frame_done_q, frame_done_d;

    logic                w_rise;
    logic                w_seq_err_set;
    logic                w_push;
    logic                w_pop;
    logic [c_FW-1:0]     w_wr_data;
    logic [c_FW-1:0]     w_rd_data;
    logic                w_fifo_empty;
    logic                w_fifo_full;

    assign w_rise = ADC && !adc_q;

`ifdef DARK_SUB_EN
    localparam logic [DATA_W-1:0] c_DARK = DARK_LEVEL[DATA_W-1:0];

    function automatic logic [DATA_W-1:0] f_dark_sub(input logic [DATA_W-1:0] s);
        return (s > c_DARK) ? (s - c_DARK) : '0;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            row_q        <= 1'b0;
            cap_q        <= '0;
            adc_q        <= 1'b0;
            seq_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            cap_q        <= cap_d;
            adc_q        <= ADC;
            seq_err_q    <= seq_err_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        cap_d         = cap_q;
        w_seq_err_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    if (NRE_1 ^ NRE_2) begin
                        // NRE_1 low selects row 1 (code 0), otherwise row 2.
                        row_d   = NRE_1;
                        cnt_d   = 4'(SETTLE);
                        state_d = ST_SETTLE;
                    end else begin
                        w_seq_err_set = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (!ADC) begin
                    state_d       = ST_IDLE;
                    w_seq_err_set = 1'b1;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
`ifdef DARK_SUB_EN
                cap_d = {f_dark_sub(adc_data[2*DATA_W-1:DATA_W]),
                         f_dark_sub(adc_data[DATA_W-1:0])};
`else
                cap_d = adc_data;
`endif
                state_d = ST_PUSH0;
            end
            ST_PUSH0: begin
                state_d = ST_PUSH1;
            end
            ST_PUSH1: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (erase) begin
            state_d       = ST_IDLE;
            w_seq_err_set = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    assign w_pop = pix.pix_ready && !w_fifo_empty;

    always_comb begin
        w_push       = !erase && ((state_q == ST_PUSH0) || (state_q == ST_PUSH1));
        w_wr_data    = {cap_q[DATA_W-1:0], row_q, 1'b0};
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        seq_err_d    = seq_err_q;

        if (state_q == ST_PUSH1) begin
            w_wr_data    = {cap_q[2*DATA_W-1:DATA_W], row_q, 1'b1};
            frame_done_d = row_q && !erase;
        end

        if (erase) begin
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
        end else begin
            // A full FIFO still takes the sample if the head leaves this cycle.
            if (w_push && w_fifo_full && !w_pop) overflow_d = 1'b1;
            if (w_seq_err_set)                   seq_err_d  = 1'b1;
        end
    end

    pix_fifo #(
        .WIDTH (c_FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (erase),
        .wr_en_i   (w_push),
        .wr_data_i (w_wr_data),
        .rd_en_i   (pix.pix_ready),
        .rd_data_o (w_rd_data),
        .empty_o   (w_fifo_empty),
        .full_o    (w_fifo_full)
    );

    assign pix.pix_valid = !w_fifo_empty;
    assign pix.pix_data  = w_rd_data[c_FW-1:2];
    assign pix.pix_row   = w_rd_data[1];
    assign pix.pix_col   = w_rd_data[0];

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign seq_err    = seq_err_q;

endmodule : pixel_readout
`default_nettype wire

// File: tb/tb_pixel_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_readout
// Purpose  : Directed self-checking bench for pixel_readout (DATA_W=8,
//            SETTLE=3, DEPTH=4, DARK_LEVEL=8). Inputs change and outputs are
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_readout;
    import pixel_readout_pkg::*;

    localparam int c_DW = 8;
    localparam int c_ST = 3;
    localparam int c_DP = 4;
    localparam int c_DL = 8;

`ifdef DARK_SUB_EN
    localparam logic [7:0] c_DARK_EXP0 = 8'h00;
    localparam logic [7:0] c_DARK_EXP1 = 8'h18;
`else
    localparam logic [7:0] c_DARK_EXP0 = 8'h05;
    localparam logic [7:0] c_DARK_EXP1 = 8'h20;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        NRE_1;
    logic        NRE_2;
    logic        ADC;
    logic        erase;
    logic [15:0] adc_data;
    logic        frame_done;
    logic        overflow;
    logic        seq_err;

    int checks = 0;
    int errors = 0;

    pixel_readout_if #(.DATA_W(c_DW)) pix_if ();

    pixel_readout #(
        .DATA_W     (c_DW),
        .SETTLE     (c_ST),
        .DEPTH      (c_DP),
        .DARK_LEVEL (c_DL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .ADC        (ADC),
        .erase      (erase),
        .adc_data   (adc_data),
        .pix        (pix_if),
        .frame_done (frame_done),
        .overflow   (overflow),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion window. Starts at a falling edge (ADC rises there, the
    // rise is seen at the next rising edge E) and returns at the falling edge
    // after E+6, i.e. just after column 1 was written, with ADC low again.
    task automatic window(input logic row, input logic [15:0] d, input bit timing);
        @(negedge clk);
        NRE_1    = row;
        NRE_2    = ~row;
        adc_data = d;
        ADC      = 1'b1;
        repeat (5) @(negedge clk);              // after E+4: sampled, not pushed
        if (timing) chk("valid_before_col0", pix_if.pix_valid, 32'd0);
        adc_data = 16'hFFFF;                    // sample already taken
        @(negedge clk);                         // after E+5: column 0 written
        if (timing) begin
            chk("valid_at_col0", pix_if.pix_valid, 32'd1);
            chk("data_at_col0", pix_if.pix_data, {24'd0, d[7:0]});
        end
        @(negedge clk);                         // after E+6: column 1 written
        ADC   = 1'b0;
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
    endtask

    task automatic pop(input string tag, input logic [7:0] d, input logic r, input logic c);
        pix_entry_t got;
        got = '{data: pix_if.pix_data, row: pix_if.pix_row, col: pix_if.pix_col};
        chk({tag, "_valid"}, pix_if.pix_valid, 32'd1);
        chk({tag, "_entry"}, 32'(got), 32'({d, r, c}));
        pix_if.pix_ready = 1'b1;
        @(negedge clk);
        pix_if.pix_ready = 1'b0;
    endtask

    task automatic erase_pulse();
        @(negedge clk);
        erase = 1'b1;
        @(negedge clk);
        erase = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        NRE_1            = 1'b1;
        NRE_2            = 1'b1;
        ADC              = 1'b0;
        erase            = 1'b0;
        adc_data         = 16'h0000;
        pix_if.pix_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", pix_if.pix_valid, 32'd0);
        chk("rst_data", pix_if.pix_data, 32'd0);
        chk("rst_frame_done", frame_done, 32'd0);
        chk("rst_overflow", overflow, 32'd0);
        chk("rst_seq_err", seq_err, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single row-1 window, column 0 timing
        window(1'b0, 16'h3A15, 1'b1);
        chk("r0_no_frame_done", frame_done, 32'd0);
        pop("w1c0", 8'h15, 1'b0, 1'b0);
        pop("w1c1", 8'h3A, 1'b0, 1'b1);
        chk("w1_empty", pix_if.pix_valid, 32'd0);

        // Row 1 then row 2: four pixels, one frame_done
        window(1'b0, 16'h2211, 1'b0);
        chk("f_r0_no_fd", frame_done, 32'd0);
        window(1'b1, 16'h8040, 1'b0);
        chk("f_fd_pulse", frame_done, 32'd1);
        pop("f0", 8'h11, 1'b0, 1'b0);
        chk("f_fd_one_cycle", frame_done, 32'd0);
        pop("f1", 8'h22, 1'b0, 1'b1);
        pop("f2", 8'h40, 1'b1, 1'b0);
        pop("f3", 8'h80, 1'b1, 1'b1);
        chk("f_empty", pix_if.pix_valid, 32'd0);

        // Overflow: three windows into a 4-deep FIFO with no pops
        window(1'b0, 16'h0201, 1'b0);
        window(1'b0, 16'h0403, 1'b0);
        chk("ov_not_yet", overflow, 32'd0);
        window(1'b0, 16'h0605, 1'b0);
        chk("ov_set", overflow, 32'd1);
        pop("ov0", 8'h01, 1'b0, 1'b0);
        pop("ov1", 8'h02, 1'b0, 1'b1);
        pop("ov2", 8'h03, 1'b0, 1'b0);
        pop("ov3", 8'h04, 1'b0, 1'b1);
        chk("ov_dropped", pix_if.pix_valid, 32'd0);
        chk("ov_sticky", overflow, 32'd1);
        window(1'b0, 16'h0807, 1'b0);
        chk("er_pre_valid", pix_if.pix_valid, 32'd1);
        erase_pulse();
        chk("er_empty", pix_if.pix_valid, 32'd0);
        chk("er_ov_clear", overflow, 32'd0);

        // Both read enables low on a rise
        @(negedge clk);
        NRE_1 = 1'b0;
        NRE_2 = 1'b0;
        ADC   = 1'b1;
        repeat (8) @(negedge clk);
        chk("both_low_seq_err", seq_err, 32'd1);
        chk("both_low_no_push", pix_if.pix_valid, 32'd0);
        ADC   = 1'b0;
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
        erase_pulse();
        chk("er_seq_clear", seq_err, 32'd0);

        // Window aborted after one settle edge
        @(negedge clk);
        NRE_1 = 1'b0;
        ADC   = 1'b1;
        repeat (2) @(negedge clk);
        ADC   = 1'b0;
        NRE_1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_seq_err", seq_err, 32'd1);
        chk("abort_no_push", pix_if.pix_valid, 32'd0);

        // Reset in the middle of SETTLE with data queued and seq_err set
        window(1'b0, 16'h7766, 1'b0);
        @(negedge clk);
        NRE_1    = 1'b0;
        adc_data = 16'h1111;
        ADC      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ADC   = 1'b0;
        NRE_1 = 1'b1;
        #1;
        chk("mrst_valid", pix_if.pix_valid, 32'd0);
        chk("mrst_data", pix_if.pix_data, 32'd0);
        chk("mrst_seq_err", seq_err, 32'd0);
        chk("mrst_frame_done", frame_done, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        window(1'b1, 16'h3A15, 1'b1);
        chk("mrst_fd", frame_done, 32'd1);
        pop("mr0", 8'h15, 1'b1, 1'b0);
        pop("mr1", 8'h3A, 1'b1, 1'b1);
        chk("mrst_seq_still_clear", seq_err, 32'd0);

        // Dark-level samples
        window(1'b0, 16'h2005, 1'b0);
        pop("dk0", c_DARK_EXP0, 1'b0, 1'b0);
        pop("dk1", c_DARK_EXP1, 1'b0, 1'b1);
        chk("dk_empty", pix_if.pix_valid, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pixel_readout
`default_nettype wire
